// File: rtl/multi_pulse_gen.sv
// Multi-channel programmable pulse generator: continuous, single-shot and burst pulse trains per channel.
// Define PULSE_GEN_TRIG_SYNC_EN to add a 2-flop synchronizer on every trig input (start latency +2 cycles).
module multi_pulse_gen #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CH_W     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [CNT_W-1:0]    cfg_data,
  input  logic [CHANNELS-1:0] trig,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_CONT   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_BURST  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_PERIOD = 2'b00;
  localparam logic [1:0] SEL_WIDTH  = 2'b01;
  localparam logic [1:0] SEL_COUNT  = 2'b10;
  localparam logic [1:0] SEL_MODE   = 2'b11;

  logic                cfg_ch_ok_c;
  logic [CHANNELS-1:0] trig_s;
  logic [CHANNELS-1:0] trig_q;

  assign cfg_ch_ok_c = (32'(cfg_ch) < CHANNELS);

`ifdef PULSE_GEN_TRIG_SYNC_EN
  logic [CHANNELS-1:0] trig_m;

  // Two-stage synchronizer for asynchronous trigger sources
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_m <= '0;
      trig_s <= '0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
    end
  end
`else
  assign trig_s = trig;
`endif

  // Trigger history for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig_q <= '0;
    else          trig_q <= trig_s;
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic [CNT_W-1:0] period_r, width_r, count_r;
    mode_e            mode_r;
    logic [CNT_W-1:0] cnt, p_a, w_a, n_a;
    mode_e            mode_a;
    state_e           state;
    logic             pulse_q, busy_q, done_q;
    logic             wr_c, start_c, abort_c, last_c;
    logic [CNT_W-1:0] count_n_c, cnt_inc_c;

    assign wr_c      = cfg_wr && cfg_ch_ok_c && (cfg_ch == CH_W'(i));
    assign start_c   = trig_s[i] && !trig_q[i] && (mode_r != MODE_OFF) && (period_r != '0);
    assign abort_c   = wr_c && (cfg_sel == SEL_MODE) && (cfg_data[1:0] == 2'b00);
    assign count_n_c = (count_r == '0) ? CNT_W'(1) : count_r;
    assign cnt_inc_c = cnt + CNT_W'(1);
    assign last_c    = (mode_a == MODE_SINGLE) ||
                       ((mode_a == MODE_BURST) && (n_a <= CNT_W'(1))) ||
                       (period_r == '0);

    // Configuration registers, written directly by the host
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period_r <= '0;
        width_r  <= '0;
        count_r  <= CNT_W'(1);
        mode_r   <= MODE_OFF;
      end else if (wr_c) begin
        case (cfg_sel)
          SEL_PERIOD: period_r <= cfg_data;
          SEL_WIDTH:  width_r  <= cfg_data;
          SEL_COUNT:  count_r  <= cfg_data;
          default:    mode_r   <= mode_e'(cfg_data[1:0]);
        endcase
      end
    end

    // Channel FSM; active copies are relatched only at period boundaries
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        p_a     <= '0;
        w_a     <= '0;
        n_a     <= '0;
        mode_a  <= MODE_OFF;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (start_c) begin
              state   <= ST_RUN;
              cnt     <= '0;
              p_a     <= period_r;
              w_a     <= width_r;
              n_a     <= count_n_c;
              mode_a  <= mode_r;
              pulse_q <= (width_r != '0);
              busy_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (abort_c) begin
              state   <= ST_IDLE;
              cnt     <= '0;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (cnt == p_a - CNT_W'(1)) begin
              if (last_c) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                cnt     <= '0;
                p_a     <= period_r;
                w_a     <= width_r;
                mode_a  <= mode_r;
                n_a     <= (mode_a == MODE_BURST) ? (n_a - CNT_W'(1)) : count_n_c;
                pulse_q <= (width_r != '0);
              end
            end else begin
              cnt     <= cnt_inc_c;
              pulse_q <= (cnt_inc_c < w_a);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = busy_q;
    assign done[i]  = done_q;
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench for multi_pulse_gen: a timeline model paints expected pulse/busy per cycle, done events are queued.
module tb_multi_pulse_gen;
  localparam int CH   = 6;
  localparam int CW   = 8;
  localparam int CHW  = 3;
  localparam int NCYC = 8192;
`ifdef PULSE_GEN_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int M_OFF = 0, M_CONT = 1, M_SINGLE = 2, M_BURST = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cfg_wr;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_sel;
  logic [CW-1:0]  cfg_data;
  logic [CH-1:0]  trig;
  logic [CH-1:0]  pulse, busy, done;

  multi_pulse_gen #(.CHANNELS(CH), .CNT_W(CW), .CH_W(CHW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .trig(trig), .pulse(pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int cyc; } ev_t;
  ev_t           dq[$];
  logic [CH-1:0] exp_p [NCYC];
  logic [CH-1:0] exp_b [NCYC];
  int            edge_n = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %b expected %b", nm, edge_n, act, exp);
    end
  endtask

  // Expected behaviour of one run: nper periods of length P, high while (offset mod P) < W
  task automatic paint(input int ch, input int s, input int p, input int w, input int nper, input bit with_done);
    for (int o = 0; o < p * nper; o++) begin
      if (s + o < NCYC) begin
        exp_b[s + o][ch] = 1'b1;
        if ((o % p) < w) exp_p[s + o][ch] = 1'b1;
      end
    end
    if (with_done) dq.push_back('{ch: ch, cyc: s + p * nper});
  endtask

  task automatic clear_from(input int ch, input int c);
    for (int t = c; t < NCYC; t++) begin
      exp_p[t][ch] = 1'b0;
      exp_b[t][ch] = 1'b0;
    end
  endtask

  // Monitor: compares DUT outputs to the scoreboard every cycle
  always @(negedge clk) begin
    logic [CH-1:0] ed;
    ed = '0;
    for (int j = dq.size() - 1; j >= 0; j--) begin
      if (dq[j].cyc == edge_n) begin
        ed[dq[j].ch] = 1'b1;
        dq.delete(j);
      end
    end
    if (edge_n < NCYC) begin
      chk("pulse", pulse, exp_p[edge_n]);
      chk("busy", busy, exp_b[edge_n]);
      chk("done", done, ed);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL timeline overflow @edge %0d", edge_n);
    end
  end

  task automatic wr(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_ch = CHW'(ch); cfg_sel = 2'(sel); cfg_data = CW'(data);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg(input int ch, input int p, input int w, input int n, input int mode);
    wr(ch, 0, p); wr(ch, 1, w); wr(ch, 2, n); wr(ch, 3, mode);
  endtask

  task automatic abort_ch(input int ch);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_ch = CHW'(ch); cfg_sel = 2'd3; cfg_data = '0;
    clear_from(ch, edge_n + 1);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Raises trig bits; s = first cycle the outputs are expected to show the start
  task automatic trig_on(input logic [CH-1:0] m, output int s);
    @(negedge clk);
    trig = trig | m;
    s = edge_n + LAT;
  endtask

  task automatic trig_off(input logic [CH-1:0] m);
    repeat (2) @(negedge clk);
    trig = trig & ~m;
  endtask

  int s;
  int p [CH];
  int w [CH];
  int n [CH];
  int md [CH];
  logic [CH-1:0] mask;
  int maxlen;

  initial begin
    for (int t = 0; t < NCYC; t++) begin exp_p[t] = '0; exp_b[t] = '0; end
    reset_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; trig = '0;
    #1;
    chk("reset_pulse", pulse, '0);
    chk("reset_busy", busy, '0);
    chk("reset_done", done, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous ch0 P=10 W=3, then stopped by a mode-off write (no done)
    cfg(0, 10, 3, 1, M_CONT);
    trig_on(6'b000001, s);
    paint(0, s, 10, 3, 8, 1'b0);
    trig_off(6'b000001);
    repeat (45) @(negedge clk);
    abort_ch(0);
    repeat (5) @(negedge clk);

    // Burst ch2 P=5 W=2 N=4
    cfg(2, 5, 2, 4, M_BURST);
    trig_on(6'b000100, s);
    paint(2, s, 5, 2, 4, 1'b1);
    trig_off(6'b000100);
    repeat (30) @(negedge clk);

    // Single-shot ch1 P=8 W=8, second trigger while running is ignored
    cfg(1, 8, 8, 1, M_SINGLE);
    trig_on(6'b000010, s);
    paint(1, s, 8, 8, 1, 1'b1);
    trig_off(6'b000010);
    @(negedge clk);
    trig[1] = 1'b1;
    trig_off(6'b000010);
    repeat (15) @(negedge clk);

    // Continuous ch3 P=6 W=2, width changed to 4 mid-period, then mode off
    cfg(3, 6, 2, 1, M_CONT);
    trig_on(6'b001000, s);
    paint(3, s, 6, 2, 1, 1'b0);
    paint(3, s + 6, 6, 4, 6, 1'b0);
    trig_off(6'b001000);
    wr(3, 1, 4);
    repeat (12) @(negedge clk);
    abort_ch(3);
    repeat (5) @(negedge clk);

    // P=0 ignores triggers; writes to nonexistent channels 6 and 7 have no effect
    cfg(4, 0, 3, 1, M_SINGLE);
    wr(7, 0, 5); wr(7, 3, M_CONT); wr(6, 0, 5); wr(6, 3, M_CONT);
    trig_on(6'b010000, s);
    trig_off(6'b010000);
    repeat (8) @(negedge clk);

    // Reset in the middle of a burst on ch5
    cfg(5, 7, 3, 4, M_BURST);
    trig_on(6'b100000, s);
    paint(5, s, 7, 3, 4, 1'b1);
    repeat (10) @(negedge clk);
    for (int c = 0; c < CH; c++) clear_from(c, edge_n + 1);
    for (int j = dq.size() - 1; j >= 0; j--) if (dq[j].cyc > edge_n) dq.delete(j);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pulse", pulse, '0);
    chk("async_rst_busy", busy, '0);
    chk("async_rst_done", done, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    cfg(5, 4, 1, 2, M_BURST);
    repeat (3) @(negedge clk);
    trig[5] = 1'b0;
    @(negedge clk);
    trig_on(6'b100000, s);
    paint(5, s, 4, 1, 2, 1'b1);
    trig_off(6'b100000);
    repeat (15) @(negedge clk);

    // Randomized single/burst runs, several channels triggered together
    for (int it = 0; it < 14; it++) begin
      mask = CH'($urandom_range(1, (1 << CH) - 1));
      for (int c = 0; c < CH; c++) begin
        if (mask[c]) begin
          p[c] = $urandom_range(1, 9);
          w[c] = $urandom_range(0, p[c] + 1);
          n[c] = $urandom_range(0, 3);
          md[c] = ($urandom_range(0, 1) == 0) ? M_SINGLE : M_BURST;
          cfg(c, p[c], w[c], n[c], md[c]);
        end
      end
      trig_on(mask, s);
      for (int c = 0; c < CH; c++) begin
        if (mask[c])
          paint(c, s, p[c], w[c], (md[c] == M_SINGLE) ? 1 : ((n[c] == 0) ? 1 : n[c]), 1'b1);
      end
      trig_off(mask);
      maxlen = 9 * 3 + 8;
      repeat (maxlen) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    n_cmp++;
    if (dq.size() != 0) begin
      n_err++;
      $display("FAIL done_pending: got %0d outstanding done events expected 0", dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameter CHANNELS, default 8, number of independent pulse channels (1..2**CH_W).
REQ-002 Parameter CNT_W, default 16, width of the period, width and count registers and counters.
REQ-003 Parameter CH_W, default 3, width of the channel-select field.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_wr  input  1  config write strobe, one cycle per write.
REQ-007 cfg_ch  input  CH_W  target channel of the write.
REQ-008 cfg_sel  input  2  target register: 00 period, 01 width, 10 burst count, 11 mode.
REQ-009 cfg_data  input  CNT_W  write data; mode uses bits [1:0].
REQ-010 trig  input  CHANNELS  per-channel start request, rising-edge sensitive.
REQ-011 pulse  output  CHANNELS  registered pulse outputs.
REQ-012 busy  output  CHANNELS  high while a channel is generating.
REQ-013 done  output  CHANNELS  one-cycle strobe at normal completion.

Function
REQ-014 Per channel: registers PERIOD (P), WIDTH (W), COUNT (N), MODE; MODE 00 off, 01 continuous, 10 single-shot, 11 burst.
REQ-015 cfg_wr with cfg_ch >= CHANNELS shall be ignored; a write updates the register on the same clock edge.
REQ-016 Per-channel FSM states IDLE and RUN; busy = (state == RUN).
REQ-017 Edge detect: start when trig[i] is 1 this cycle and was 0 last cycle, MODE != 00 and P != 0; sampled at edge k, pulse[i]=1 and busy[i]=1 from edge k+1 (if W != 0).
REQ-018 On start, active copies P_a, W_a, N_a latch from registers; writes during RUN take effect only at the next period boundary.
REQ-019 In RUN, counter cnt counts 0..P_a-1, +1 per cycle; pulse = (cnt < W_a).
REQ-020 W_a = 0 -> pulse stays low, timing unchanged; W_a >= P_a -> pulse high for the entire period.
REQ-021 At cnt = P_a-1: continuous -> cnt=0, relatch actives, continue indefinitely.
REQ-022 At cnt = P_a-1: single-shot -> IDLE next cycle, done=1 for that one cycle.
REQ-023 At cnt = P_a-1: burst -> if remaining = 1 go IDLE with done; else decrement, cnt=0, relatch P_a/W_a; N = 0 treated as 1.
REQ-024 Relatched P = 0 at a boundary -> channel goes IDLE with done.
REQ-025 Trigger edges during RUN shall be ignored (no restart, no queuing).
REQ-026 Write of MODE = 00 to a channel in RUN aborts next edge: IDLE, pulse=0, no done.
REQ-027 Write of a non-off MODE during RUN keeps the current mode until the next period boundary.
REQ-028 Channels are fully independent; simultaneous triggers on several channels all start in the same cycle.
REQ-029 Counter arithmetic is unsigned CNT_W bits; P = 2**CNT_W-1 is the maximum period.

Reset
REQ-030 reset_n low immediately forces pulse, busy, done to 0 and all FSMs to IDLE, independent of clk.
REQ-031 Reset values: PERIOD=0, WIDTH=0, COUNT=1, MODE=00, counters 0, edge-detect history 0.
REQ-032 Reset mid-pulse terminates without done; after release a fresh trig edge is required.

Configuration
REQ-033 Macro PULSE_GEN_TRIG_SYNC_EN defined: trig passes through a 2-flop synchronizer per channel before edge detection; start latency becomes k+3.
REQ-034 Macro not defined: trig is edge-detected directly (assumed synchronous); start latency k+1.

Verification
REQ-035 Ch0 P=10, W=3, mode continuous, trig[0] rising -> pulse[0] high 3 / low 7 cycles, repeating; busy[0] stays 1; done never.
REQ-036 Ch2 P=5, W=2, N=4, mode burst, trig[2] -> exactly 4 pulses of 2 cycles, 20 busy cycles, one done[2] strobe, then IDLE.
REQ-037 Ch1 single-shot P=8, W=8 -> pulse[1] high 8 cycles contiguous, done[1] once; second trig during RUN ignored.
REQ-038 Ch3 continuous P=6 W=2, write W=4 mid-period -> current period unchanged, next period high 4 cycles; write MODE=00 -> pulse low next edge, no done.
REQ-039 reset_n low mid-burst on ch5 -> all outputs 0 asynchronously; after release no activity until new trig edge; write cfg_ch=7 with CHANNELS=6 -> no effect.
REQ-040 With PULSE_GEN_TRIG_SYNC_EN, trig edge at k -> pulse at k+3; without, k+1; P=0 -> trig ignored in both builds.
